// File: rtl/sram_arb2_if.sv
// sram_arb2_if: bundle of the two requester ports and the shared SRAM port.
//   m0_* / m1_* : request (valid/ready/write/addr/wdata/wstrb) and read response (rvalid/rdata)
//   sram_*      : single-port SRAM request and combinational read data
// Modports: slave = arbiter side, master = requesters + SRAM side.
interface sram_arb2_if;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned STRB_W = 4;

  logic              m0_req_valid;
  logic              m0_req_ready;
  logic              m0_req_write;
  logic [ADDR_W-1:0] m0_req_addr;
  logic [DATA_W-1:0] m0_req_wdata;
  logic [STRB_W-1:0] m0_req_wstrb;
  logic              m0_rvalid;
  logic [DATA_W-1:0] m0_rdata;

  logic              m1_req_valid;
  logic              m1_req_ready;
  logic              m1_req_write;
  logic [ADDR_W-1:0] m1_req_addr;
  logic [DATA_W-1:0] m1_req_wdata;
  logic [STRB_W-1:0] m1_req_wstrb;
  logic              m1_rvalid;
  logic [DATA_W-1:0] m1_rdata;

  logic              sram_req_valid;
  logic              sram_req_write;
  logic [ADDR_W-1:0] sram_req_addr;
  logic [DATA_W-1:0] sram_req_wdata;
  logic [STRB_W-1:0] sram_req_wstrb;
  logic [DATA_W-1:0] sram_rdata;

  modport slave (
    input  m0_req_valid, m0_req_write, m0_req_addr, m0_req_wdata, m0_req_wstrb,
    input  m1_req_valid, m1_req_write, m1_req_addr, m1_req_wdata, m1_req_wstrb,
    input  sram_rdata,
    output m0_req_ready, m0_rvalid, m0_rdata,
    output m1_req_ready, m1_rvalid, m1_rdata,
    output sram_req_valid, sram_req_write, sram_req_addr, sram_req_wdata, sram_req_wstrb
  );

  modport master (
    output m0_req_valid, m0_req_write, m0_req_addr, m0_req_wdata, m0_req_wstrb,
    output m1_req_valid, m1_req_write, m1_req_addr, m1_req_wdata, m1_req_wstrb,
    output sram_rdata,
    input  m0_req_ready, m0_rvalid, m0_rdata,
    input  m1_req_ready, m1_rvalid, m1_rdata,
    input  sram_req_valid, sram_req_write, sram_req_addr, sram_req_wdata, sram_req_wstrb
  );
endinterface

// File: rtl/sram_arb2.sv
// sram_arb2: two-requester arbiter sharing one single-port SRAM.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : sram_arb2_if.slave (m0/m1 request + response ports, SRAM port)
// Grant and SRAM request are combinational; read responses are registered.
// A per-port wait counter forces a grant after STARVE_LIMIT blocked cycles.
// Option: define SRAM_ARB_RR_EN for round-robin contention; otherwise port 0
// has fixed priority and no pointer flop is built.
module sram_arb2 #(
  parameter int unsigned STARVE_LIMIT = 8
) (
  input logic        clk,
  input logic        rst_n,
  sram_arb2_if.slave bus
);
  localparam int unsigned CNT_W  = 8;
  localparam int unsigned DATA_W = 32;
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0]  wait0_q, wait1_q;
  logic              rvalid0_q, rvalid1_q;
  logic [DATA_W-1:0] rdata0_q, rdata1_q;
  logic              grant0, grant1;
  logic              starve0, starve1;

  assign starve0 = (wait0_q == LIMIT);
  assign starve1 = (wait1_q == LIMIT);

`ifdef SRAM_ARB_RR_EN
  // Pointer holds the port preferred on the next contention (0 after reset).
  logic ptr_q, ptr_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= 1'b0;
    else        ptr_q <= ptr_d;
  end

  // Next pointer: the port that did not just win; unchanged without an accept.
  always_comb begin
    ptr_d = ptr_q;
    if (grant0)      ptr_d = 1'b1;
    else if (grant1) ptr_d = 1'b0;
  end
`endif

  // Grant: sole requester, then a lone starved port, then the base policy.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (bus.m0_req_valid && !bus.m1_req_valid) begin
      grant0 = 1'b1;
    end else if (!bus.m0_req_valid && bus.m1_req_valid) begin
      grant1 = 1'b1;
    end else if (bus.m0_req_valid && bus.m1_req_valid) begin
      if (starve0 != starve1) begin
        grant0 = starve0;
        grant1 = starve1;
      end else begin
`ifdef SRAM_ARB_RR_EN
        grant0 = !ptr_q;
        grant1 = ptr_q;
`else
        grant0 = 1'b1;
`endif
      end
    end
  end

  // SRAM mux: winner's fields, all zero when idle.
  always_comb begin
    bus.sram_req_valid = grant0 | grant1;
    bus.sram_req_write = 1'b0;
    bus.sram_req_addr  = '0;
    bus.sram_req_wdata = '0;
    bus.sram_req_wstrb = '0;
    if (grant0) begin
      bus.sram_req_write = bus.m0_req_write;
      bus.sram_req_addr  = bus.m0_req_addr;
      bus.sram_req_wdata = bus.m0_req_wdata;
      bus.sram_req_wstrb = bus.m0_req_wstrb;
    end else if (grant1) begin
      bus.sram_req_write = bus.m1_req_write;
      bus.sram_req_addr  = bus.m1_req_addr;
      bus.sram_req_wdata = bus.m1_req_wdata;
      bus.sram_req_wstrb = bus.m1_req_wstrb;
    end
  end

  assign bus.m0_req_ready = grant0;
  assign bus.m1_req_ready = grant1;

  // Wait counters: count blocked cycles, saturate at the limit, clear otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait0_q <= '0;
      wait1_q <= '0;
    end else begin
      if (!bus.m0_req_valid || grant0) wait0_q <= '0;
      else if (!starve0)               wait0_q <= wait0_q + CNT_W'(1);
      if (!bus.m1_req_valid || grant1) wait1_q <= '0;
      else if (!starve1)               wait1_q <= wait1_q + CNT_W'(1);
    end
  end

  // Read response: capture SRAM data on an accepted read, valid for one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
    end else begin
      rvalid0_q <= grant0 && !bus.m0_req_write;
      rvalid1_q <= grant1 && !bus.m1_req_write;
      if (grant0 && !bus.m0_req_write) rdata0_q <= bus.sram_rdata;
      if (grant1 && !bus.m1_req_write) rdata1_q <= bus.sram_rdata;
    end
  end

  assign bus.m0_rvalid = rvalid0_q;
  assign bus.m1_rvalid = rvalid1_q;
  assign bus.m0_rdata  = rdata0_q;
  assign bus.m1_rdata  = rdata1_q;
endmodule

// File: tb/tb_sram_arb2.sv
// tb_sram_arb2: directed + randomized bench for sram_arb2 with a behavioural
// SRAM and a transaction-level reference model of the arbitration rules.
module tb_sram_arb2;
  localparam int LIMIT = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sram_arb2_if bus();

  sram_arb2 #(.STARVE_LIMIT(LIMIT)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  // Behavioural single-port SRAM: 64 words, byte-enabled writes at posedge.
  logic [31:0] mem [64];
  always @(posedge clk) begin
    if (bus.sram_req_valid && bus.sram_req_write)
      for (int b = 0; b < 4; b++)
        if (bus.sram_req_wstrb[b])
          mem[bus.sram_req_addr[7:2]][8*b +: 8] <= bus.sram_req_wdata[8*b +: 8];
  end
  assign bus.sram_rdata = mem[bus.sram_req_addr[7:2]];

  int n_tests = 0;
  int n_fail  = 0;

  // Requests currently presented by each port.
  logic        qv [2];
  logic        qw [2];
  logic [31:0] qa [2];
  logic [31:0] qd [2];
  logic [3:0]  qs [2];

  // Reference model state.
  int          bw [2];
  logic [31:0] exp_mem [64];
  logic        exp_rv [2];
  logic [31:0] exp_rd [2];
`ifdef SRAM_ARB_RR_EN
  int          pref;
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  // Which port the rules say wins this cycle (-1 = none).
  function automatic int pick();
    if (!qv[0] && !qv[1]) return -1;
    if (qv[0] && !qv[1])  return 0;
    if (!qv[0] && qv[1])  return 1;
    if ((bw[0] == LIMIT) && (bw[1] != LIMIT)) return 0;
    if ((bw[1] == LIMIT) && (bw[0] != LIMIT)) return 1;
`ifdef SRAM_ARB_RR_EN
    return pref;
`else
    return 0;
`endif
  endfunction

  task automatic model_reset();
    for (int p = 0; p < 2; p++) begin
      bw[p] = 0; exp_rv[p] = 1'b0; exp_rd[p] = '0;
    end
`ifdef SRAM_ARB_RR_EN
    pref = 0;
`endif
  endtask

  task automatic new_req(input int p, input logic w, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] s);
    qv[p] = 1'b1; qw[p] = w; qa[p] = a; qd[p] = d; qs[p] = s;
  endtask

  task automatic rand_req(input int p);
    logic [31:0] r;
    logic [5:0]  idx;
    r   = $urandom();
    idx = 6'($urandom_range(0, 63));
    new_req(p, 1'($urandom_range(0, 1)), {r[31:8], idx, 2'b00}, $urandom(),
            4'($urandom_range(0, 15)));
  endtask

  // One clock cycle: drive, check grant/mux, clock, check response, update model.
  task automatic step(output int win, output int obs);
    @(negedge clk);
    bus.m0_req_valid = qv[0]; bus.m0_req_write = qw[0]; bus.m0_req_addr = qa[0];
    bus.m0_req_wdata = qd[0]; bus.m0_req_wstrb = qs[0];
    bus.m1_req_valid = qv[1]; bus.m1_req_write = qw[1]; bus.m1_req_addr = qa[1];
    bus.m1_req_wdata = qd[1]; bus.m1_req_wstrb = qs[1];
    #1;
    win = pick();
    obs = bus.m0_req_ready ? 0 : (bus.m1_req_ready ? 1 : -1);
    chk("m0_ready", 32'(bus.m0_req_ready), 32'(win == 0));
    chk("m1_ready", 32'(bus.m1_req_ready), 32'(win == 1));
    chk("sram_valid", 32'(bus.sram_req_valid), 32'(win >= 0));
    if (win >= 0) begin
      chk("sram_write", 32'(bus.sram_req_write), 32'(qw[win]));
      chk("sram_addr", bus.sram_req_addr, qa[win]);
      chk("sram_wdata", bus.sram_req_wdata, qd[win]);
      chk("sram_wstrb", 32'(bus.sram_req_wstrb), 32'(qs[win]));
    end else begin
      chk("sram_idle_ctl", {27'd0, bus.sram_req_write, bus.sram_req_wstrb}, 32'd0);
      chk("sram_idle_addr", bus.sram_req_addr, 32'd0);
      chk("sram_idle_wdata", bus.sram_req_wdata, 32'd0);
    end
    @(posedge clk);
    #1;
    exp_rv[0] = 1'b0;
    exp_rv[1] = 1'b0;
    if (win >= 0) begin
      if (qw[win]) exp_mem[qa[win][7:2]] = merge(exp_mem[qa[win][7:2]], qd[win], qs[win]);
      else begin
        exp_rv[win] = 1'b1;
        exp_rd[win] = exp_mem[qa[win][7:2]];
      end
`ifdef SRAM_ARB_RR_EN
      pref = 1 - win;
`endif
    end
    for (int p = 0; p < 2; p++)
      bw[p] = (qv[p] && win != p) ? ((bw[p] < LIMIT) ? bw[p] + 1 : bw[p]) : 0;
    chk("m0_rvalid", 32'(bus.m0_rvalid), 32'(exp_rv[0]));
    chk("m1_rvalid", 32'(bus.m1_rvalid), 32'(exp_rv[1]));
    chk("m0_rdata", bus.m0_rdata, exp_rd[0]);
    chk("m1_rdata", bus.m1_rdata, exp_rd[1]);
  endtask

  task automatic do_reset();
    @(negedge clk);
    qv[0] = 1'b0; qv[1] = 1'b0;
    bus.m0_req_valid = 1'b0; bus.m1_req_valid = 1'b0;
    rst_n = 1'b0;
    #2;
    model_reset();
    chk("rst_m0_rvalid", 32'(bus.m0_rvalid), 32'd0);
    chk("rst_m1_rvalid", 32'(bus.m1_rvalid), 32'd0);
    rst_n = 1'b1;
  endtask

  initial begin
    int w, g;
    int pat [8];
    int first_m1;

    for (int p = 0; p < 2; p++) begin
      qv[p] = 1'b0; qw[p] = 1'b0; qa[p] = '0; qd[p] = '0; qs[p] = '0;
    end
    bus.m0_req_valid = 1'b0; bus.m0_req_write = 1'b0; bus.m0_req_addr = '0;
    bus.m0_req_wdata = '0;   bus.m0_req_wstrb = '0;
    bus.m1_req_valid = 1'b0; bus.m1_req_write = 1'b0; bus.m1_req_addr = '0;
    bus.m1_req_wdata = '0;   bus.m1_req_wstrb = '0;
    model_reset();

    // Reset state.
    #12;
    chk("reset_m0_rvalid", 32'(bus.m0_rvalid), 32'd0);
    chk("reset_m1_rvalid", 32'(bus.m1_rvalid), 32'd0);
    chk("reset_m0_rdata", bus.m0_rdata, 32'd0);
    chk("reset_m1_rdata", bus.m1_rdata, 32'd0);
    chk("reset_ready", {30'd0, bus.m0_req_ready, bus.m1_req_ready}, 32'd0);
    chk("reset_sram_valid", 32'(bus.sram_req_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Preload every SRAM word through port 1 full-word writes.
    for (int i = 0; i < 64; i++) begin
      logic [31:0] d;
      d = (i == 16) ? 32'hDEADBEEF : ((i == 2) ? 32'hFFFFFFFF : $urandom());
      new_req(1, 1'b1, 32'(i * 4), d, 4'hF);
      step(w, g);
      if (w >= 0) qv[w] = 1'b0;
    end

    // Single read on port 0, then an idle cycle.
    new_req(0, 1'b0, 32'h0000_0040, 32'd0, 4'h0);
    step(w, g);
    chk("single_read_grant", 32'(g), 32'd0);
    chk("single_read_data", bus.m0_rdata, 32'hDEADBEEF);
    qv[0] = 1'b0;
    step(w, g);
    chk("single_read_rvalid_drop", 32'(bus.m0_rvalid), 32'd0);

    // Byte-masked write then read on port 1.
    new_req(1, 1'b1, 32'h0000_0008, 32'h11223344, 4'b0101);
    step(w, g);
    qv[1] = 1'b0;
    new_req(1, 1'b0, 32'h0000_0008, 32'd0, 4'h0);
    step(w, g);
    qv[1] = 1'b0;
    chk("byte_write_data", bus.m1_rdata, 32'hFF22FF44);

    // Contention from reset: both ports continuously reading.
`ifdef SRAM_ARB_RR_EN
    pat = '{0, 1, 0, 1, 0, 1, 0, 1};
`else
    pat = '{0, 0, 0, 1, 0, 0, 0, 1};
`endif
    do_reset();
    for (int k = 0; k < 8; k++) begin
      for (int p = 0; p < 2; p++)
        if (!qv[p]) new_req(p, 1'b0, 32'($urandom_range(0, 63) * 4), 32'd0, 4'h0);
      step(w, g);
      chk("contention_grant", 32'(g), 32'(pat[k]));
      if (w >= 0) qv[w] = 1'b0;
    end

    // Asynchronous reset right after an accepted read.
    qv[0] = 1'b0; qv[1] = 1'b0;
    new_req(0, 1'b0, 32'h0000_0040, 32'd0, 4'h0);
    step(w, g);
    qv[0] = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_rvalid", 32'(bus.m0_rvalid), 32'd0);
    chk("async_rst_rdata", bus.m0_rdata, 32'd0);
    model_reset();
    rst_n = 1'b1;
    new_req(0, 1'b0, 32'h0000_0010, 32'd0, 4'h0);
    new_req(1, 1'b0, 32'h0000_0020, 32'd0, 4'h0);
    step(w, g);
    chk("ptr_after_reset", 32'(g), 32'd0);
    if (w >= 0) qv[w] = 1'b0;

    // Valid drop: m1 blocked 2 cycles, drops valid, reasserts.
    do_reset();
    first_m1 = -1;
    new_req(1, 1'b0, 32'h0000_0030, 32'd0, 4'h0);
    for (int k = 0; k < 9; k++) begin
      if (!qv[0]) new_req(0, 1'b0, 32'($urandom_range(0, 63) * 4), 32'd0, 4'h0);
      if (k == 2) qv[1] = 1'b0;
      if (k == 3 && first_m1 < 0) qv[1] = 1'b1;
      step(w, g);
      if (g == 1 && first_m1 < 0) first_m1 = k;
      if (w >= 0) qv[w] = 1'b0;
    end
`ifndef SRAM_ARB_RR_EN
    chk("valid_drop_first_m1_grant", 32'(first_m1), 32'd6);
`endif

    // Randomized traffic against the reference model.
    qv[0] = 1'b0; qv[1] = 1'b0;
    for (int k = 0; k < 400; k++) begin
      for (int p = 0; p < 2; p++)
        if (!qv[p] && $urandom_range(0, 99) < 60) rand_req(p);
      step(w, g);
      if (w >= 0) qv[w] = 1'b0;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
